// File: rtl/mem_responder_pkg.sv
// Shared types: common_pkg carries the bus-level types, and mem_pkg carries the responder FSM
// encoding, the default parameters and the out-of-range address helper.
package common_pkg;
   typedef logic [19:0]  pptr_t;
   typedef logic [127:0] cacheline_t;
   typedef logic [2:0]   threadid_t;
endpackage

package mem_pkg;
   import common_pkg::*;

   localparam int LATENCY_DEFAULT   = 5;
   localparam int MEM_LINES_DEFAULT = 1024;
   localparam int LINE_OFFSET_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Any address bit above the line index field marks the access as outside the array.
   function automatic logic addr_out_of_range(input pptr_t addr, input int idx_w);
      pptr_t upper;
      upper = addr >> (LINE_OFFSET_W + idx_w);
      return (upper != 20'd0);
   endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a cache (master) and mem_responder (slave).
interface mem_responder_if;
   import common_pkg::*;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   pptr_t      req_addr;
   cacheline_t req_wdata;
   threadid_t  req_tid;
   logic       rsp_valid;
   logic       rsp_ready;
   cacheline_t rsp_rdata;
   threadid_t  rsp_tid;
   logic       rsp_write;
   logic       rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_tid, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_tid, rsp_write, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_tid, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_tid, rsp_write, rsp_err
   );
endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port line storage, synchronous write and combinational read.
// Contents are never reset; they only change through the write port.
module mem_array
   import common_pkg::*;
#(
   parameter int LINES = 1024,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  cacheline_t       wdata,
   output cacheline_t       rdata
);
   cacheline_t mem_r [LINES];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[idx] <= wdata;
      end
   end

   assign rdata = mem_r[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency cache-line memory model with one outstanding request.
// Optional feature: define MEM_ERR_EN to flag addresses beyond MEM_LINES instead of wrapping.
module mem_responder
   import common_pkg::*;
   import mem_pkg::*;
#(
   parameter int LATENCY   = LATENCY_DEFAULT,
   parameter int MEM_LINES = MEM_LINES_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);
   localparam int         IDX_W    = $clog2(MEM_LINES);
   localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

   state_t           state_r;
   state_t           state_s;
   logic [7:0]       cnt_r;
   logic [7:0]       cnt_s;
   logic [IDX_W-1:0] idx_r;
   cacheline_t       wdata_r;
   threadid_t        tid_r;
   logic             write_r;
   logic             err_r;

   cacheline_t       rsp_rdata_r;
   threadid_t        rsp_tid_r;
   logic             rsp_write_r;
   logic             rsp_err_r;

   logic             accept_s;
   logic             to_resp_s;
   logic             req_err_s;
   logic [IDX_W-1:0] req_idx_s;
   logic [IDX_W-1:0] arr_idx_s;
   logic             cur_err_s;
   logic             cur_write_s;
   threadid_t        cur_tid_s;
   cacheline_t       cur_wdata_s;
   cacheline_t       arr_rdata_s;
   logic             mem_we_s;
   logic             unused_addr_s;

`ifdef MEM_ERR_EN
   assign req_err_s = addr_out_of_range(bus.req_addr, IDX_W);
`else
   assign req_err_s = 1'b0;
`endif

   // Offset bits (and, without the error check, the upper bits) carry no meaning here.
   assign unused_addr_s = ^bus.req_addr;
   assign req_idx_s     = bus.req_addr[LINE_OFFSET_W +: IDX_W];

   // Next-state and latency counter
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      accept_s  = 1'b0;
      to_resp_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               accept_s = 1'b1;
               cnt_s    = LOAD_VAL;
               if (LATENCY == 1) begin
                  state_s   = RESP;
                  to_resp_s = 1'b1;
               end else begin
                  state_s = BUSY;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            // Leaving when the counter would hit zero places rsp_valid LATENCY cycles after accept.
            if (cnt_r <= 8'd1) begin
               state_s   = RESP;
               cnt_s     = 8'd0;
               to_resp_s = 1'b1;
            end else begin
               state_s = BUSY;
               cnt_s   = cnt_r - 8'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // Array access uses live request fields when a single-cycle latency skips the capture stage.
   always_comb begin
      if (state_r == IDLE) begin
         arr_idx_s   = req_idx_s;
         cur_err_s   = req_err_s;
         cur_write_s = bus.req_write;
         cur_tid_s   = bus.req_tid;
         cur_wdata_s = bus.req_wdata;
      end else begin
         arr_idx_s   = idx_r;
         cur_err_s   = err_r;
         cur_write_s = write_r;
         cur_tid_s   = tid_r;
         cur_wdata_s = wdata_r;
      end
      mem_we_s = to_resp_s & cur_write_s & ~cur_err_s & ~reset;
   end

   // FSM state and request capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         idx_r   <= {IDX_W{1'b0}};
         wdata_r <= 128'd0;
         tid_r   <= 3'd0;
         write_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (accept_s) begin
            idx_r   <= req_idx_s;
            wdata_r <= bus.req_wdata;
            tid_r   <= bus.req_tid;
            write_r <= bus.req_write;
            err_r   <= req_err_s;
         end
      end
   end

   // Response registers load on the edge entering RESP and hold until the next response
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_rdata_r <= 128'd0;
         rsp_tid_r   <= 3'd0;
         rsp_write_r <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else if (to_resp_s) begin
         if (cur_write_s || cur_err_s) begin
            rsp_rdata_r <= 128'd0;
         end else begin
            rsp_rdata_r <= arr_rdata_s;
         end
         rsp_tid_r   <= cur_tid_s;
         rsp_write_r <= cur_write_s;
         rsp_err_r   <= cur_err_s;
      end
   end

   mem_array #(
      .LINES (MEM_LINES),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we_s),
      .idx   (arr_idx_s),
      .wdata (cur_wdata_s),
      .rdata (arr_rdata_s)
   );

   assign bus.req_ready = (state_r == IDLE);
   assign bus.rsp_valid = (state_r == RESP);
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_tid   = rsp_tid_r;
   assign bus.rsp_write = rsp_write_r;
   assign bus.rsp_err   = rsp_err_r;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 5, meaning cycles from request acceptance to rsp_valid; legal range 1..255.
REQ-002 The block SHALL have parameter MEM_LINES, default 1024, meaning number of 128-bit lines held; a power of two, at most 65536.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit, a cache line request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit, the block can accept a request.
REQ-008 The block SHALL have port req_write, input, 1 bit, 1 = writeback, 0 = line fill.
REQ-009 The block SHALL have port req_addr, input, 20 bits (pptr_t), the physical address; offset bits [3:0] are ignored.
REQ-010 The block SHALL have port req_wdata, input, 128 bits (cacheline_t), the writeback data.
REQ-011 The block SHALL have port req_tid, input, 3 bits (threadid_t), the requesting thread.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit, a response is present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit, the cache accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, 128 bits, the line read; 0 for writes.
REQ-015 The block SHALL have ports rsp_tid (output, 3 bits) and rsp_write (output, 1 bit), echoing the captured req_tid and req_write.
REQ-016 The block SHALL have port rsp_err, output, 1 bit, the address is out of range (see Configuration).

Function
REQ-017 The block SHALL use an FSM with states IDLE, BUSY and RESP; one request is outstanding at most.
REQ-018 req_ready SHALL equal 1 only in IDLE; a request is accepted in any cycle where req_valid and req_ready are both 1.
REQ-019 On acceptance, the block SHALL register addr, wdata, tid and write, load the counter with LATENCY-1, and go to BUSY, or to RESP if LATENCY = 1.
REQ-020 In BUSY, the counter SHALL decrement each cycle; at 0 the block goes to RESP, so rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-021 Line index SHALL be addr[4 +: log2(MEM_LINES)]; higher address bits are ignored unless MEM_ERR_EN is defined.
REQ-022 The memory write for a writeback SHALL happen on the BUSY-to-RESP transition edge; rsp_rdata is the line content sampled on that same edge.
REQ-023 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs stable until rsp_ready is 1; on that edge the block returns to IDLE.
REQ-024 Back-to-back: req_ready SHALL rise the cycle after the response handshake; no same-cycle response/accept bypass.
REQ-025 A read following a write to the same line SHALL return the written data.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, req_ready 1 in the following cycle, and rsp_valid, rsp_rdata, rsp_tid, rsp_write, rsp_err all 0.
REQ-027 Reset mid-operation SHALL discard the outstanding request, and a pending writeback SHALL NOT modify memory.
REQ-028 Memory contents SHALL NOT be cleared by reset; they are loaded by simulation init only.

Configuration
REQ-029 With MEM_ERR_EN defined, an address with any bit above the index range set SHALL give rsp_err 1 and rsp_rdata 0, and a write SHALL NOT modify memory.
REQ-030 Without MEM_ERR_EN, rsp_err SHALL be tied 0 and addresses SHALL wrap modulo MEM_LINES.

Structure
REQ-031 pptr_t, cacheline_t and threadid_t SHALL come from the common package; a new package mem_pkg holds the FSM state enum and the LATENCY default constant.
REQ-032 The line storage SHALL be one sub-module, mem_array (single port, synchronous write, combinational read).

Verification
REQ-033 Read after reset: fill request at 0x00010, LATENCY 5, accepted at cycle 0 -> rsp_valid at cycle 5 with the preloaded line 1, and rsp_tid echoed.
REQ-034 Write then read: write 0x00020 data 0xDEADBEEF_..._0123 with tid 3, then read 0x00020 -> read returns the same 128 bits, and rsp_write is 1 then 0.
REQ-035 Backpressure: rsp_ready held 0 for 4 cycles -> rsp_valid and data stay stable and req_ready stays 0; handshake in cycle 5 -> req_ready is 1 next cycle.
REQ-036 Reset during BUSY of a write at 0x00030 -> outputs are 0 next cycle and a later read of 0x00030 returns the old data.
REQ-037 With MEM_ERR_EN and MEM_LINES 1024, a read of 0x40000 -> rsp_err 1 and rdata 0; without the macro, the same read returns line 0.
REQ-038 LATENCY 1: accept at cycle 0 -> rsp_valid at cycle 1.
